// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register, BYPASS/IDCODE
// and a bank of user data registers with parallel capture/update ports.
module jtag_tap_ctrl #(
   parameter int          IR_LEN      = 4,
   parameter int          NUM_USER_DR = 2,
   parameter int          USER_DR_W   = 16,
   parameter logic [31:0] IDCODE_VAL  = 32'h1234_5679
) (
   input  logic                               tck,
   input  logic                               trst,
   input  logic                               tms,
   input  logic                               tdi,
   output logic                               tdo,
   output logic                               tdo_en,
   output logic [3:0]                         tap_state,
   output logic [IR_LEN-1:0]                  ir_o,
   input  logic [NUM_USER_DR*USER_DR_W-1:0]   user_dr_i,
   output logic [NUM_USER_DR*USER_DR_W-1:0]   user_dr_o,
   output logic [NUM_USER_DR-1:0]             user_dr_upd
);

   typedef enum logic [3:0] {
      S_EX2DR = 4'h0,
      S_EX1DR = 4'h1,
      S_SHDR  = 4'h2,
      S_PAUDR = 4'h3,
      S_SELIR = 4'h4,
      S_UPDDR = 4'h5,
      S_CAPDR = 4'h6,
      S_SELDR = 4'h7,
      S_EX2IR = 4'h8,
      S_EX1IR = 4'h9,
      S_SHIR  = 4'hA,
      S_PAUIR = 4'hB,
      S_RTI   = 4'hC,
      S_UPDIR = 4'hD,
      S_CAPIR = 4'hE,
      S_TLR   = 4'hF
   } tap_state_t;

   localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);

   tap_state_t               r_state;
   tap_state_t               w_next;
   logic [IR_LEN-1:0]        r_ir;
   logic [IR_LEN-1:0]        r_ir_shift;
   logic                     r_bypass;
   logic [31:0]              r_idcode_shift;
   logic                     r_tdo;
   logic                     r_tdo_en;
   logic                     w_sel_idcode;
   logic                     w_sel_bypass;
   logic [NUM_USER_DR-1:0]   w_sel_user;
   logic [NUM_USER_DR-1:0]   w_user_lsb;
   logic                     w_dr_lsb;

   assign tap_state = r_state;
   assign ir_o      = r_ir;
   assign tdo       = r_tdo;
   assign tdo_en    = r_tdo_en;

   always_ff @(posedge tck or posedge trst) begin
      if (trst) r_state <= S_TLR;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_TLR:   w_next = tms ? S_TLR   : S_RTI;
         S_RTI:   w_next = tms ? S_SELDR : S_RTI;
         S_SELDR: w_next = tms ? S_SELIR : S_CAPDR;
         S_CAPDR: w_next = tms ? S_EX1DR : S_SHDR;
         S_SHDR:  w_next = tms ? S_EX1DR : S_SHDR;
         S_EX1DR: w_next = tms ? S_UPDDR : S_PAUDR;
         S_PAUDR: w_next = tms ? S_EX2DR : S_PAUDR;
         S_EX2DR: w_next = tms ? S_UPDDR : S_SHDR;
         S_UPDDR: w_next = tms ? S_SELDR : S_RTI;
         S_SELIR: w_next = tms ? S_TLR   : S_CAPIR;
         S_CAPIR: w_next = tms ? S_EX1IR : S_SHIR;
         S_SHIR:  w_next = tms ? S_EX1IR : S_SHIR;
         S_EX1IR: w_next = tms ? S_UPDIR : S_PAUIR;
         S_PAUIR: w_next = tms ? S_EX2IR : S_PAUIR;
         S_EX2IR: w_next = tms ? S_UPDIR : S_SHIR;
         S_UPDIR: w_next = tms ? S_SELDR : S_RTI;
         default: w_next = S_TLR;
      endcase
   end

   // Anything that is neither IDCODE nor a user code (including all ones) selects BYPASS.
   assign w_sel_idcode = (r_ir == IR_IDCODE);
   assign w_sel_bypass = !w_sel_idcode && !(|w_sel_user);

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_ir       <= IR_IDCODE;
         r_ir_shift <= '0;
      end else begin
         case (r_state)
            S_TLR:   r_ir       <= IR_IDCODE;
            S_CAPIR: r_ir_shift <= IR_LEN'(1);
            S_SHIR:  r_ir_shift <= {tdi, r_ir_shift[IR_LEN-1:1]};
            S_UPDIR: r_ir       <= r_ir_shift;
            default: ;
         endcase
      end
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         r_bypass       <= 1'b0;
         r_idcode_shift <= '0;
      end else if (r_state == S_CAPDR) begin
         if (w_sel_bypass) r_bypass       <= 1'b0;
         if (w_sel_idcode) r_idcode_shift <= IDCODE_VAL;
      end else if (r_state == S_SHDR) begin
         if (w_sel_bypass) r_bypass       <= tdi;
         if (w_sel_idcode) r_idcode_shift <= {tdi, r_idcode_shift[31:1]};
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_USER_DR; gi++) begin : g_user
         logic [USER_DR_W-1:0] r_shift;
         logic [USER_DR_W-1:0] r_upd_val;
         logic                 r_upd_stb;

         assign w_sel_user[gi] = (r_ir == IR_LEN'(gi + 2));
         assign w_user_lsb[gi] = r_shift[0];
         assign user_dr_o[gi*USER_DR_W +: USER_DR_W] = r_upd_val;
         assign user_dr_upd[gi] = r_upd_stb;

         // Shift written arithmetically so a 1-bit register needs no special case.
         always_ff @(posedge tck or posedge trst) begin
            if (trst) begin
               r_shift <= '0;
            end else if (w_sel_user[gi]) begin
               if (r_state == S_CAPDR)
                  r_shift <= user_dr_i[gi*USER_DR_W +: USER_DR_W];
               else if (r_state == S_SHDR)
                  r_shift <= (r_shift >> 1) | (USER_DR_W'(tdi) << (USER_DR_W - 1));
            end
         end

         always_ff @(posedge tck or posedge trst) begin
            if (trst) begin
               r_upd_val <= '0;
               r_upd_stb <= 1'b0;
            end else begin
               r_upd_stb <= 1'b0;
               if (w_sel_user[gi] && r_state == S_UPDDR) begin
                  r_upd_val <= r_shift;
                  r_upd_stb <= 1'b1;
               end
            end
         end
      end
   endgenerate

   always_comb begin
      w_dr_lsb = 1'b0;
      if (w_sel_idcode)      w_dr_lsb = r_idcode_shift[0];
      else if (w_sel_bypass) w_dr_lsb = r_bypass;
      else                   w_dr_lsb = |(w_sel_user & w_user_lsb);
   end

   // tdo changes on the falling edge so the far end samples it cleanly on the next rise.
   always_ff @(negedge tck or posedge trst) begin
      if (trst) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else if (r_state == S_SHDR) begin
         r_tdo    <= w_dr_lsb;
         r_tdo_en <= 1'b1;
      end else if (r_state == S_SHIR) begin
         r_tdo    <= r_ir_shift[0];
         r_tdo_en <= 1'b1;
      end else begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end
   end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Parametrised IEEE 1149.1-style TAP controller, driven by the same tck/tms/tdi/tdo pin set as the existing JTAG interface.
- Contains:
  - the 16-state TAP FSM,
  - an instruction register of configurable length,
  - BYPASS and IDCODE data registers,
  - NUM_USER_DR user data registers with parallel capture/update ports.
- Sits between the JTAG pins and the on-chip debug/config logic.
- Replaces fixed-width, single-register scan handling with generalised width and channel count.

Parameters:
- IR_LEN, 4, instruction register length in bits; must be >= 2.
- NUM_USER_DR, 2, number of user data registers; requires NUM_USER_DR+2 < 2**IR_LEN-1.
- USER_DR_W, 16, width of each user data register; must be >= 1.
- IDCODE_VAL, 32'h1234_5679, 32-bit device ID; bit 0 must be 1.

Ports:
- tck  input  1  JTAG test clock; the only clock.
- trst  input  1  asynchronous, active-high reset.
- tms  input  1  test mode select, sampled on posedge tck.
- tdi  input  1  serial data in, sampled on posedge tck.
- tdo  output  1  serial data out, updated on negedge tck.
- tdo_en  output  1  tdo output enable; 1 only while shifting.
- tap_state  output  4  current FSM state code.
- ir_o  output  IR_LEN  current (updated) instruction.
- user_dr_i  input  NUM_USER_DR*USER_DR_W  parallel capture values; register k occupies bits [k*USER_DR_W +: USER_DR_W].
- user_dr_o  output  NUM_USER_DR*USER_DR_W  parallel update values; same packing as user_dr_i.
- user_dr_upd  output  NUM_USER_DR  one-tck update strobe per user register.

Behaviour:

Reset:
- trst=1 asynchronously forces:
  - tap_state=TLR (4'hF)
  - ir_o=IDCODE instruction (1)
  - user_dr_o=0
  - user_dr_upd=0
  - tdo=0
  - tdo_en=0
  - all shift registers cleared
- Reset mid-scan aborts the scan. No update of ir_o or user_dr_o occurs.

State codes and transitions (standard 1149.1, next state for tms=0 / tms=1):

| State | Code | tms=0 | tms=1 |
|---|---|---|---|
| TLR | F | RTI | TLR |
| RTI | C | RTI | SelDR |
| SelDR | 7 | CapDR | SelIR |
| CapDR | 6 | ShDR | Ex1DR |
| ShDR | 2 | ShDR | Ex1DR |
| Ex1DR | 1 | PauDR | UpdDR |
| PauDR | 3 | PauDR | Ex2DR |
| Ex2DR | 0 | ShDR | UpdDR |
| UpdDR | 5 | RTI | SelDR |
| SelIR | 4 | CapIR | TLR |
| CapIR | E | ShIR | Ex1IR |
| ShIR | A | ShIR | Ex1IR |
| Ex1IR | 9 | PauIR | UpdIR |
| PauIR | B | PauIR | Ex2IR |
| Ex2IR | 8 | ShIR | UpdIR |
| UpdIR | D | RTI | SelDR |

- Five consecutive tms=1 edges reach TLR from any state.
- Every posedge tck spent in TLR loads ir_o=1. user_dr_o is retained.

Instruction decode (from ir_o):
- all ones → BYPASS.
- 1 → IDCODE.
- 2+k, for k < NUM_USER_DR → USER k.
- any other value → BYPASS.

Posedge tck actions, keyed on the current state:
- CapIR: IR shift register loads {0..., 2'b01}.
- ShIR: IR shift register shifts right; tdi enters the MSB.
- UpdIR: ir_o loads the IR shift register at the edge leaving UpdIR.
- CapDR, per selected register:
  - BYPASS loads 0.
  - IDCODE loads IDCODE_VAL.
  - USER k loads slice k of user_dr_i.
- ShDR: the selected register shifts right, LSB first; tdi enters the MSB. BYPASS is a 1-bit delay.
- UpdDR (USER k only): at the edge leaving UpdDR, slice k of user_dr_o loads the shift register and user_dr_upd[k] is set to 1.
- user_dr_upd bits are high for exactly one tck cycle. They clear at the next posedge.
- IDCODE and BYPASS have no update effect.
- Unselected user registers and slices are untouched.

Negedge tck actions:
- State ShDR or ShIR: tdo = LSB of the active shift register; tdo_en=1.
- Any other state: tdo=0, tdo_en=0.

Boundaries:
- Shifting more bits than the register length passes tdi through with a delay equal to the register length.
- Fewer bits followed by an update writes a partially shifted value; this is legal.
- PauDR/PauIR hold shift contents indefinitely.
- Changing ir_o never alters user_dr_o.

Test Plan:
1. Reset: assert trst mid-ShDR (tap_state=2) → immediately tap_state=F, tdo_en=0, ir_o=4'h1, user_dr_upd=0, user_dr_o unchanged at 0.
2. IDCODE read: after reset, tms 0,1,0,0, then 31×tms=0 and 1×tms=1 → tdo serially shows 32'h1234_5679 LSB first (first bit 1), tdo_en=1 for exactly 32 negedges.
3. IR scan: shift IR value 4'h2 → first two tdo bits are 1,0, then 0,0; ir_o=4'h2 one posedge after UpdIR; tap_state codes follow E,A,A,A,A,9,D.
4. USER0 scan: ir_o=2, user_dr_i[15:0]=16'hA5C3, shift in 16'h3C5A → tdo yields A5C3 LSB first; after UpdDR user_dr_o[15:0]=16'h3C5A, user_dr_o[31:16] unchanged, user_dr_upd=2'b01 for one cycle.
5. Bypass/unknown: ir_o=4'hF, then separately 4'h9; shift tdi 1,0,1,1 → tdo 0,1,0,1 in both cases; no user_dr_upd pulse.
6. Soft reset: from PauDR apply tms=1 ×5 → tap_state=F, ir_o=4'h1, user_dr_o retained.
